// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch queue.
package inst_fetch_pkg;

   localparam int INST_ADDR_W = 32;
   localparam int INST_W      = 32;

   localparam logic [INST_ADDR_W-1:0] ZERO_WORD = 32'h0000_0000;
   localparam logic [INST_ADDR_W-1:0] PC_STEP   = 32'h0000_0004;

   // FETCH: a request may be issued. DRAIN: a squashed request is still outstanding.
   typedef enum logic [0:0] {
      FETCH_ST_FETCH = 1'b0,
      FETCH_ST_DRAIN = 1'b1
   } fetch_st_e;

   // One prefetch queue entry: the fetch address and the word returned for it.
   typedef struct packed {
      logic [INST_ADDR_W-1:0] pc;
      logic [INST_W-1:0]      inst;
   } fetch_entry_t;

   // Force a redirect target onto a word boundary.
   function automatic logic [INST_ADDR_W-1:0] align_pc(input logic [INST_ADDR_W-1:0] pc);
      return {pc[INST_ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Prefetch queue: DEPTH entries of {pc, inst}, with push/pop/clear, occupancy count and
// empty/full flags. The head entry is presented combinationally on rdata.
module inst_fetch_fifo
   import inst_fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         clear,
   input  fetch_entry_t                 wdata,
   output fetch_entry_t                 rdata,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   fetch_entry_t  mem_r [DEPTH];
   logic [PW-1:0] rd_ptr_r;
   logic [PW-1:0] wr_ptr_r;
   logic [CW-1:0] count_r;
   logic          do_push_s;
   logic          do_pop_s;

   // Pointer advance with wrap, so DEPTH need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
      logic [PW-1:0] nxt;
      if (ptr == LAST_PTR) begin
         nxt = {PW{1'b0}};
      end else begin
         nxt = ptr + PW'(1);
      end
      return nxt;
   endfunction

   // Qualify push/pop against occupancy; a push into a full queue is only legal alongside a pop.
   always_comb begin
      do_pop_s  = pop && (count_r != {CW{1'b0}});
      do_push_s = push && ((count_r != FULL_CNT) || do_pop_s);
   end

   // Pointer and occupancy bookkeeping; clear empties the queue regardless of push/pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_r <= {PW{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else if (clear) begin
         rd_ptr_r <= {PW{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= ptr_inc(wr_ptr_r);
         end
         if (do_pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; written at the tail on every accepted push.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (do_push_s && !clear) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   assign rdata = mem_r[rd_ptr_r];
   assign count = count_r;
   assign empty = (count_r == {CW{1'b0}});
   assign full  = (count_r == FULL_CNT);

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: generates sequential PCs, fetches over a req/ack handshake with
// variable wait states, buffers words in a prefetch queue and presents the queue head to IF/ID.
// A flush redirects fetch; a request already in flight is drained and its data discarded.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000,
   parameter int                     DEPTH    = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall_i,
   input  logic                   flush_i,
   input  logic [INST_ADDR_W-1:0] new_pc_i,
   output logic                   mem_req_o,
   output logic [INST_ADDR_W-1:0] mem_addr_o,
   input  logic                   mem_ack_i,
   input  logic [INST_W-1:0]      mem_rdata_i,
   output logic                   if_valid_o,
   output logic [INST_ADDR_W-1:0] if_pc_o,
   output logic [INST_W-1:0]      if_inst_o
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

   fetch_st_e              state_r;
   fetch_st_e              state_next_s;
   logic                   req_r;
   logic                   req_next_s;
   logic [INST_ADDR_W-1:0] addr_r;
   logic [INST_ADDR_W-1:0] addr_next_s;
   logic [INST_ADDR_W-1:0] target_r;
   logic [INST_ADDR_W-1:0] target_next_s;
   logic [INST_ADDR_W-1:0] flush_pc_s;

   logic                   ack_s;
   logic                   push_s;
   logic                   pop_s;
   logic                   room_s;
   logic [CW-1:0]          count_s;
   logic [CW-1:0]          count_next_s;
   logic                   empty_s;
   logic                   full_s;
   fetch_entry_t           head_s;
   fetch_entry_t           push_data_s;

   inst_fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .pop   (pop_s),
      .clear (flush_i),
      .wdata (push_data_s),
      .rdata (head_s),
      .count (count_s),
      .empty (empty_s),
      .full  (full_s)
   );

   // Handshake qualification and queue control; an ack with no request pending is ignored.
   always_comb begin
      ack_s        = req_r && mem_ack_i;
      pop_s        = if_valid_o && !stall_i && !flush_i;
      push_s       = (state_r == FETCH_ST_FETCH) && ack_s && !flush_i && (!full_s || pop_s);
      flush_pc_s   = align_pc(new_pc_i);
      push_data_s  = {addr_r, mem_rdata_i};
      count_next_s = count_s + CW'(push_s) - CW'(pop_s);
      room_s       = (count_next_s < DEPTH_CNT);
   end

   // Present the queue head to IF/ID, substituting a zero word (NOP) when empty.
   always_comb begin
      if_valid_o = !empty_s;
      if (if_valid_o) begin
         if_pc_o   = head_s.pc;
         if_inst_o = head_s.inst;
      end else begin
         if_pc_o   = ZERO_WORD;
         if_inst_o = ZERO_WORD;
      end
   end

   // State, request and address registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= FETCH_ST_FETCH;
         req_r    <= 1'b0;
         addr_r   <= RESET_PC;
         target_r <= RESET_PC;
      end else begin
         state_r  <= state_next_s;
         req_r    <= req_next_s;
         addr_r   <= addr_next_s;
         target_r <= target_next_s;
      end
   end

   // Next-state: enter DRAIN when a flush squashes a request that has not yet been acked.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         FETCH_ST_FETCH: begin
            if (flush_i && req_r && !ack_s) begin
               state_next_s = FETCH_ST_DRAIN;
            end else begin
               state_next_s = FETCH_ST_FETCH;
            end
         end
         FETCH_ST_DRAIN: begin
            if (flush_i) begin
               state_next_s = FETCH_ST_DRAIN;
            end else if (ack_s) begin
               state_next_s = FETCH_ST_FETCH;
            end else begin
               state_next_s = FETCH_ST_DRAIN;
            end
         end
         default: state_next_s = FETCH_ST_FETCH;
      endcase
   end

   // Next request/address: hold while a request waits, advance on ack, retarget on flush.
   always_comb begin
      req_next_s    = req_r;
      addr_next_s   = addr_r;
      target_next_s = target_r;
      case (state_r)
         FETCH_ST_FETCH: begin
            if (flush_i) begin
               target_next_s = flush_pc_s;
               if (req_r && !ack_s) begin
                  req_next_s  = req_r;
                  addr_next_s = addr_r;
               end else begin
                  req_next_s  = 1'b1;
                  addr_next_s = flush_pc_s;
               end
            end else if (ack_s) begin
               addr_next_s = addr_r + PC_STEP;
               req_next_s  = room_s;
            end else if (!req_r) begin
               req_next_s  = room_s;
            end else begin
               req_next_s  = req_r;
            end
         end
         FETCH_ST_DRAIN: begin
            if (flush_i) begin
               target_next_s = flush_pc_s;
            end else if (ack_s) begin
               req_next_s  = 1'b1;
               addr_next_s = target_r;
            end else begin
               req_next_s  = req_r;
            end
         end
         default: begin
            req_next_s    = 1'b0;
            addr_next_s   = RESET_PC;
            target_next_s = RESET_PC;
         end
      endcase
   end

   assign mem_req_o  = req_r;
   assign mem_addr_o = addr_r;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: memory model with programmable wait states returning
// addr ^ 32'hA5A5_0000, one task per scenario with hand-computed expectations.
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] new_pc = 32'h0000_0000;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;

   int   vectors = 0;
   int   miscompares = 0;
   int   n_wait = 0;
   int   wait_cnt = 0;
   logic ack_force = 1'b0;

   inst_fetch #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall_i     (stall),
      .flush_i     (flush),
      .new_pc_i    (new_pc),
      .mem_req_o   (mem_req),
      .mem_addr_o  (mem_addr),
      .mem_ack_i   (mem_ack),
      .mem_rdata_i (mem_rdata),
      .if_valid_o  (if_valid),
      .if_pc_o     (if_pc),
      .if_inst_o   (if_inst)
   );

   always #5 clk = ~clk;

   // Memory model: ack after n_wait wait cycles of a held request.
   assign mem_ack   = ack_force | (mem_req && (wait_cnt == n_wait));
   assign mem_rdata = mem_addr ^ 32'hA5A5_0000;

   always @(posedge clk) begin
      if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
      else                     wait_cnt <= 0;
   end

   function automatic logic [31:0] exp_inst(input logic [31:0] pc);
      return pc ^ 32'hA5A5_0000;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; stall = 1'b0; flush = 1'b0; ack_force = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; n_wait = 0;
      repeat (2) @(negedge clk);
      vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %0h want 0", mem_req); end
      vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h want 00000000", mem_addr); end
      vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0h want 0", if_valid); end
      vectors++; if (if_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want 00000000", if_pc); end
      vectors++; if (if_inst !== 32'h0) begin miscompares++; $display("FAIL reset_inst: got %h want 00000000", if_inst); end
   endtask

   task automatic test_sequential();
      logic [31:0] ep;
      n_wait = 0; do_reset();
      @(negedge clk);
      vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL seq_first_req: got %0h want 1", mem_req); end
      vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL seq_first_addr: got %h want 00000000", mem_addr); end
      vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL seq_first_valid: got %0h want 0", if_valid); end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         ep = 32'(i * 4);
         vectors++; if (if_valid !== 1'b1) begin miscompares++; $display("FAIL seq_valid[%0d]: got %0h want 1", i, if_valid); end
         vectors++; if (if_pc !== ep) begin miscompares++; $display("FAIL seq_pc[%0d]: got %h want %h", i, if_pc, ep); end
         vectors++; if (if_inst !== exp_inst(ep)) begin miscompares++; $display("FAIL seq_inst[%0d]: got %h want %h", i, if_inst, exp_inst(ep)); end
         vectors++; if (mem_addr !== ep + 32'd4) begin miscompares++; $display("FAIL seq_addr[%0d]: got %h want %h", i, mem_addr, ep + 32'd4); end
      end
   endtask

   task automatic test_wait_states();
      logic        ev;
      logic [31:0] ep, ei, ea;
      n_wait = 3; do_reset();
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         ev = (k >= 5) && (((k - 5) % 4) == 0);
         ep = ev ? 32'(((k - 5) / 4) * 4) : 32'h0;
         ei = ev ? exp_inst(ep) : 32'h0;
         ea = 32'(((k - 1) / 4) * 4);
         vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL ws_req c%0d: got %0h want 1", k, mem_req); end
         vectors++; if (mem_addr !== ea) begin miscompares++; $display("FAIL ws_addr c%0d: got %h want %h", k, mem_addr, ea); end
         vectors++; if (if_valid !== ev) begin miscompares++; $display("FAIL ws_valid c%0d: got %0h want %0h", k, if_valid, ev); end
         vectors++; if (if_pc !== ep) begin miscompares++; $display("FAIL ws_pc c%0d: got %h want %h", k, if_pc, ep); end
         vectors++; if (if_inst !== ei) begin miscompares++; $display("FAIL ws_inst c%0d: got %h want %h", k, if_inst, ei); end
      end
   endtask

   task automatic test_stall();
      logic [31:0] ep;
      n_wait = 0; do_reset();
      repeat (2) @(negedge clk);
      vectors++; if (if_pc !== 32'h0 || if_valid !== 1'b1) begin miscompares++; $display("FAIL stall_pre: got valid %0h pc %h want 1 00000000", if_valid, if_pc); end
      stall = 1'b1;
      for (int k = 3; k <= 7; k++) begin
         @(negedge clk);
         vectors++; if (if_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid c%0d: got %0h want 1", k, if_valid); end
         vectors++; if (if_pc !== 32'h0) begin miscompares++; $display("FAIL stall_pc c%0d: got %h want 00000000", k, if_pc); end
         vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL stall_req c%0d: got %0h want 0", k, mem_req); end
      end
      stall = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         ep = 32'(i * 4);
         vectors++; if (if_valid !== 1'b1) begin miscompares++; $display("FAIL resume_valid[%0d]: got %0h want 1", i, if_valid); end
         vectors++; if (if_pc !== ep) begin miscompares++; $display("FAIL resume_pc[%0d]: got %h want %h", i, if_pc, ep); end
         vectors++; if (if_inst !== exp_inst(ep)) begin miscompares++; $display("FAIL resume_inst[%0d]: got %h want %h", i, if_inst, exp_inst(ep)); end
      end
   endtask

   task automatic test_flush_drain();
      n_wait = 0; do_reset();
      repeat (5) @(negedge clk);
      vectors++; if (mem_addr !== 32'h10 || mem_req !== 1'b1) begin miscompares++; $display("FAIL drain_setup: got req %0h addr %h want 1 00000010", mem_req, mem_addr); end
      n_wait = 2; flush = 1'b1; new_pc = 32'h0000_0103;
      for (int k = 6; k <= 7; k++) begin
         @(negedge clk);
         flush = 1'b0;
         vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin miscompares++; $display("FAIL drain_hold c%0d: got req %0h addr %h want 1 00000010", k, mem_req, mem_addr); end
         vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL drain_valid c%0d: got %0h want 0", k, if_valid); end
      end
      for (int k = 8; k <= 10; k++) begin
         @(negedge clk);
         vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin miscompares++; $display("FAIL redirect_req c%0d: got req %0h addr %h want 1 00000100", k, mem_req, mem_addr); end
         vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL redirect_valid c%0d: got %0h want 0", k, if_valid); end
      end
      @(negedge clk);
      vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin miscompares++; $display("FAIL redirect_first: got valid %0h pc %h want 1 00000100", if_valid, if_pc); end
      vectors++; if (if_inst !== 32'hA5A5_0100) begin miscompares++; $display("FAIL redirect_inst: got %h want a5a50100", if_inst); end
   endtask

   task automatic test_flush_ack_stall();
      n_wait = 0; do_reset();
      repeat (2) @(negedge clk);
      stall = 1'b1; flush = 1'b1; new_pc = 32'h0000_0040;
      @(negedge clk);
      stall = 1'b0; flush = 1'b0;
      vectors++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0) begin miscompares++; $display("FAIL fas_empty: got valid %0h pc %h inst %h want 0 0 0", if_valid, if_pc, if_inst); end
      vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin miscompares++; $display("FAIL fas_req: got req %0h addr %h want 1 00000040", mem_req, mem_addr); end
      @(negedge clk);
      vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h40) begin miscompares++; $display("FAIL fas_first: got valid %0h pc %h want 1 00000040", if_valid, if_pc); end
      @(negedge clk);
      vectors++; if (if_pc !== 32'h44) begin miscompares++; $display("FAIL fas_second: got %h want 00000044", if_pc); end
      stall = 1'b1;
      @(negedge clk);
      vectors++; if (if_pc !== 32'h44 || mem_req !== 1'b0) begin miscompares++; $display("FAIL idle_pre: got pc %h req %0h want 00000044 0", if_pc, mem_req); end
      flush = 1'b1; new_pc = 32'hFFFF_FFFE;
      @(negedge clk);
      flush = 1'b0; stall = 1'b0;
      vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL idle_flush_valid: got %0h want 0", if_valid); end
      vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL idle_flush_req: got req %0h addr %h want 1 fffffffc", mem_req, mem_addr); end
      @(negedge clk);
      vectors++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_inst !== 32'h5A5A_FFFC) begin miscompares++; $display("FAIL wrap_head: got valid %0h pc %h inst %h want 1 fffffffc 5a5afffc", if_valid, if_pc, if_inst); end
      vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_addr: got %h want 00000000", mem_addr); end
      @(negedge clk);
      vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'hA5A5_0000) begin miscompares++; $display("FAIL wrap_next: got valid %0h pc %h inst %h want 1 00000000 a5a50000", if_valid, if_pc, if_inst); end
   endtask

   task automatic test_reset_mid();
      n_wait = 3; do_reset();
      repeat (2) @(negedge clk);
      vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL mid_pre_req: got %0h want 1", mem_req); end
      #1 rst = 1'b1;
      #1;
      vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL mid_async_req: got %0h want 0", mem_req); end
      vectors++; if (mem_addr !== 32'h0 || if_valid !== 1'b0) begin miscompares++; $display("FAIL mid_async_state: got addr %h valid %0h want 00000000 0", mem_addr, if_valid); end
      @(negedge clk);
      rst = 1'b0; ack_force = 1'b1;
      @(negedge clk);
      ack_force = 1'b0;
      vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL stray_ack_valid: got %0h want 0", if_valid); end
      vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin miscompares++; $display("FAIL restart_req: got req %0h addr %h want 1 00000000", mem_req, mem_addr); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_wait_states();
      test_stall();
      test_flush_drain();
      test_flush_ack_stall();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
